// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full_adder cell.
// Operands arrive over an in_valid/in_ready handshake; the sum is formed
// LSB-first, one bit per clock, and returned over out_valid/out_ready.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow port ovf.

// One-bit full adder cell shared by the serial datapath.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);
   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             w_accept;
   logic             w_last;
   logic             w_fa_s;
   logic             w_fa_cout;

   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);

   full_adder u_full_adder (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_cin  (r_carry),
      .o_s    (w_fa_s),
      .o_cout (w_fa_cout)
   );

   // State register.
   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state and handshake decode; handshake outputs depend on state only.
   always_comb begin
      // NOTE: defaults first so no path through this block can infer a latch.
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next_state = S_SHIFT;
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (r_cnt == LAST_BIT) w_next_state = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Serial datapath: load on accept, one full-adder step per SHIFT cycle.
   // NOTE: every datapath flop is reset because reset must clear sum/cout at once
   // and discard any in-flight operation; these are a few flops, not a memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a_sh  <= a;
         r_b_sh  <= b;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= cin;
         r_cout  <= 1'b0;
      end else if (r_state == S_SHIFT) begin
         r_a_sh  <= r_a_sh >> 1;
         r_b_sh  <= r_b_sh >> 1;
         r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
         r_cnt   <= r_cnt + 1'b1;
         r_carry <= w_fa_cout;
         if (w_last) r_cout <= w_fa_cout;
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   // Signed overflow: carry into the MSB differs from carry out of the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_ovf <= 1'b0;
      else if (w_accept) r_ovf <= 1'b0;
      else if (w_last)   r_ovf <= r_carry ^ w_fa_cout;
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). Results are compared with
// plain integer arithmetic; ovf is checked when SERIAL_ADDER_OVF_EN is defined.
`timescale 1ns/1ps
module tb_serial_adder;

   localparam int WIDTH = 8;
   localparam int TIMEOUT = 4 * WIDTH;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
     ,.ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: full-precision addition, then split into sum/cout/ovf.
   task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                         input logic op_cin, input int stall);
      int                   full;
      int                   sfull;
      logic [WIDTH-1:0]     exp_sum;
      logic                 exp_cout;
      logic                 exp_ovf;
      logic [WIDTH-1:0]     prev_sum;
      logic                 prev_cout;
      int                   cycles;

      full     = int'(op_a) + int'(op_b) + int'(op_cin);
      exp_sum  = full[WIDTH-1:0];
      exp_cout = full[WIDTH];
      sfull    = int'($signed(op_a)) + int'($signed(op_b)) + int'(op_cin);
      exp_ovf  = (sfull > (2**(WIDTH-1) - 1)) || (sfull < -(2**(WIDTH-1)));

      @(negedge clk);
      prev_sum  = sum;
      prev_cout = cout;
      check("idle_in_ready", in_ready, 1'b1);
      a = op_a; b = op_b; cin = op_cin; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      check("accept_cleared_sum", sum, 0);
      check("busy_in_shift", busy, 1'b1);
      cycles = 0;
      while (!out_valid && cycles < TIMEOUT) begin
         @(posedge clk);
         @(negedge clk);
         cycles++;
         if (!out_valid) check("in_ready_shift", in_ready, 1'b0);
      end
      check("latency", cycles, WIDTH);
      check("sum", sum, exp_sum);
      check("cout", cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", ovf, exp_ovf);
`endif
      // Back-pressure while junk is presented on the input side.
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'($urandom);
         a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
         check("stall_out_valid", out_valid, 1'b1);
         check("stall_in_ready", in_ready, 1'b0);
         check("stall_sum", sum, exp_sum);
         check("stall_cout", cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
         check("stall_ovf", ovf, exp_ovf);
`endif
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_in_ready", in_ready, 1'b1);
      check("post_out_valid", out_valid, 1'b0);
      check("post_busy", busy, 1'b0);
      check("hold_sum", sum, exp_sum);
      check("hold_cout", cout, exp_cout);
      if (prev_sum !== sum) ; // previous result is overwritten only by the new op
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      run_op(8'h3C, 8'h0F, 1'b0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 0);
      run_op(8'hFF, 8'hFF, 1'b1, 0);
      run_op(8'h7F, 8'h01, 1'b0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 5);
      run_op(8'h80, 8'h80, 1'b0, 1);
      run_op(8'h00, 8'h00, 1'b1, 0);

      // Reset in the middle of an operation.
      @(negedge clk);
      a = 8'h55; b = 8'h33; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_sum", sum, 0);
      check("midrst_cout", cout, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst_no_result", seen, 0);

      // Randomized operations with random back-pressure.
      for (int n = 0; n < 40; n++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

- Bit-serial WIDTH-bit adder.
- Accepts two operands and a carry-in over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, through a single instance of the team's one-bit `full_adder` cell, with a registered carry.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake; it is the sequencing stage that feeds `full_adder` in area-constrained datapaths.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b and cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry-out of the MSB.
- busy  output  1  high in SHIFT or DONE.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a and b into shift registers, load cin into the carry register, clear cnt and sum, and go to SHIFT.
- SHIFT:
  - Each cycle, feed a_sh[0], b_sh[0] and carry to `full_adder`.
  - Shift the S output into sum from the MSB side: sum <= {S, sum[WIDTH-1:1]}.
  - carry <= Cout.
  - Shift a_sh and b_sh right by 1.
  - Increment cnt.
  - When cnt==WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; cout equals the carry register.
  - sum, cout and ovf are held stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE.
- Input outside IDLE: in_valid is ignored in SHIFT and DONE, and a, b and cin may change freely.
- Width rules:
  - cnt is $clog2(WIDTH) bits.
  - sum is exactly WIDTH bits; the true (WIDTH+1)-bit result is {cout, sum}.
- Output hold: sum and cout keep their last value after returning to IDLE, until the next accept clears them.
- Reset (asserted at any time, including mid-SHIFT or in DONE):
  - Immediately: state=IDLE, sum=0, cout=0, carry=0, cnt=0, out_valid=0, busy=0, ovf=0.
  - in_ready=1.
  - An in-flight operation is discarded, and no result is presented.

## Timing
- in_ready, out_valid and busy are decoded combinationally from state only, with no combinational path from in_valid or out_ready.
- Latency: operands are accepted on edge E0; out_valid rises after edge E_WIDTH, which is WIDTH cycles after the accept.
- Throughput: one result per WIDTH+2 cycles with out_ready tied high (accept, WIDTH shifts, one DONE cycle).
- Back-to-back: after the DONE handshake edge, in_ready=1 in the next cycle, so a new accept takes one cycle in IDLE minimum.
- Back-pressure: out_ready low in DONE holds the state indefinitely with stable outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Port ovf exists.
  - On the final SHIFT cycle, ovf <= carry_into_MSB ^ Cout_of_MSB (two's-complement overflow).
  - ovf is valid with out_valid and cleared on the next accept.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst_n=0 mid-SHIFT with a=0x55 -> next cycle out_valid=0, busy=0, in_ready=1, sum=0x00, cout=0; no result is ever presented.
- Basic (WIDTH=8): a=0x3C, b=0x0F, cin=0, out_ready=1 -> out_valid exactly 8 cycles after accept, sum=0x4B, cout=0.
- Full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- Carry-in: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Back-pressure and ignored input: hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid -> sum, cout and out_valid stable, in_ready=0; then out_ready=1 -> in_ready=1 the following cycle.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0xFF, b=0x01 -> ovf=0.
